// File: rtl/truth_table_sweeper_if.sv
// Control, status and logic-under-test drive/capture signals for truth_table_sweeper.
// The sweeper uses the slave view; the bench or host controller uses the master view.
interface truth_table_sweeper_if;
  logic        start;
  logic        abort;
  logic        obs_out;
  logic        drv_in1;
  logic        drv_in2;
  logic        drv_in3;
  logic        drv_in4;
  logic        busy;
  logic        done;
  logic [15:0] table_obs;
  logic [15:0] err_mask;
  logic [15:0] unstable_mask;
  logic        match;

  modport slave (
    input  start, abort, obs_out,
    output drv_in1, drv_in2, drv_in3, drv_in4,
    output busy, done, table_obs, err_mask, unstable_mask, match
  );

  modport master (
    output start, abort, obs_out,
    input  drv_in1, drv_in2, drv_in3, drv_in4,
    input  busy, done, table_obs, err_mask, unstable_mask, match
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a 4-input logic block through all 16 rows, double-samples its synchronized
// output at the end of each settle window and compares the table against EXPECTED.
module truth_table_sweeper #(
  parameter logic [15:0] EXPECTED      = 16'h1284,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMP_A = 3'd3,
    SAMP_B = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  row, row_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        samp_a, samp_a_nxt;
  logic [3:0]  drv, drv_nxt;
  logic        busy, busy_nxt;
  logic        done, done_nxt;
  logic [15:0] table_obs, table_obs_nxt;
  logic [15:0] err_mask, err_mask_nxt;
  logic [15:0] unstable_mask, unstable_mask_nxt;
  logic        match, match_nxt;
  logic        obs_meta_p0;
  logic        obs_sync_p1;
  logic [3:0]  bit_idx;

  // Row i lands in bit (15-i), which for a 4-bit index is simply ~i.
  assign bit_idx = ~row;

  // Stage p0/p1: two-flop synchronizer for the asynchronous observed output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_meta_p0 <= 1'b0;
      obs_sync_p1 <= 1'b0;
    end else begin
      obs_meta_p0 <= bus.obs_out;
      obs_sync_p1 <= obs_meta_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= 4'd0;
      cnt           <= 8'd0;
      samp_a        <= 1'b0;
      drv           <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      table_obs     <= 16'd0;
      err_mask      <= 16'd0;
      unstable_mask <= 16'd0;
      match         <= 1'b0;
    end else begin
      state         <= state_nxt;
      row           <= row_nxt;
      cnt           <= cnt_nxt;
      samp_a        <= samp_a_nxt;
      drv           <= drv_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      table_obs     <= table_obs_nxt;
      err_mask      <= err_mask_nxt;
      unstable_mask <= unstable_mask_nxt;
      match         <= match_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    row_nxt           = row;
    cnt_nxt           = cnt;
    samp_a_nxt        = samp_a;
    drv_nxt           = drv;
    busy_nxt          = busy;
    done_nxt          = 1'b0;
    table_obs_nxt     = table_obs;
    err_mask_nxt      = err_mask;
    unstable_mask_nxt = unstable_mask;
    match_nxt         = match;

    case (state)
      IDLE: begin
        // busy lingers one cycle after DONE so it still covers the done pulse.
        busy_nxt = 1'b0;
        drv_nxt  = 4'd0;
        if (bus.start) begin
          state_nxt         = DRIVE;
          row_nxt           = 4'd0;
          busy_nxt          = 1'b1;
          table_obs_nxt     = 16'd0;
          err_mask_nxt      = 16'd0;
          unstable_mask_nxt = 16'd0;
          match_nxt         = 1'b0;
        end
      end
      DRIVE: begin
        drv_nxt   = row;
        cnt_nxt   = SETTLE_LOAD;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          state_nxt = SAMP_A;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      SAMP_A: begin
        samp_a_nxt = obs_sync_p1;
        state_nxt  = SAMP_B;
      end
      SAMP_B: begin
        table_obs_nxt[bit_idx]     = obs_sync_p1;
        unstable_mask_nxt[bit_idx] = samp_a ^ obs_sync_p1;
        if (row == 4'd15) begin
          state_nxt = DONE;
        end else begin
          row_nxt   = row + 4'd1;
          state_nxt = DRIVE;
        end
      end
      DONE: begin
        done_nxt     = 1'b1;
        err_mask_nxt = table_obs ^ EXPECTED;
        match_nxt    = ((table_obs ^ EXPECTED) == 16'd0) && (unstable_mask == 16'd0);
        drv_nxt      = 4'd0;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides everything, including a start seen in the same cycle.
    if (bus.abort) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      drv_nxt   = 4'd0;
      done_nxt  = 1'b0;
      if (state != IDLE) begin
        match_nxt     = 1'b0;
        table_obs_nxt = table_obs;
        err_mask_nxt  = err_mask;
      end else begin
        table_obs_nxt     = table_obs;
        err_mask_nxt      = err_mask;
        unstable_mask_nxt = unstable_mask;
        match_nxt         = match;
      end
    end
  end

  assign bus.drv_in1       = drv[3];
  assign bus.drv_in2       = drv[2];
  assign bus.drv_in3       = drv[1];
  assign bus.drv_in4       = drv[0];
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.table_obs     = table_obs;
  assign bus.err_mask      = err_mask;
  assign bus.unstable_mask = unstable_mask;
  assign bus.match         = match;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: sweeps a modelled logic block under several fault patterns,
// plus abort, start/abort collision, held start and asynchronous reset.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   mode;
  logic glitch;

  truth_table_sweeper_if bus ();

  truth_table_sweeper #(
    .EXPECTED      (16'h1284),
    .SETTLE_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model(input logic [3:0] d);
    logic i1, i2, i3, i4;
    i1 = d[3]; i2 = d[2]; i3 = d[1]; i4 = d[0];
    return ((i2 ^ i4) & i3 & ~i1) | (~(i2 ^ i4) & i1 & ~i3);
  endfunction

  logic [3:0] drv;
  assign drv = {bus.drv_in1, bus.drv_in2, bus.drv_in3, bus.drv_in4};

  // mode 0: good block, 1: output stuck at 0, 2: row 6 inverted
  always_comb begin
    logic m;
    m = model(drv);
    if (mode == 1) m = 1'b0;
    if (mode == 2 && drv == 4'b0110) m = ~m;
    bus.obs_out = m ^ glitch;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Waits for done, counting cycles from the accept edge; lat starts at ticks already taken.
  task automatic wait_done(inout int lat);
    while (bus.done !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic sweep(output int lat);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    wait_done(lat);
  endtask

  int lat;
  int ndone;

  initial begin
    errors = 0; checks = 0; mode = 0; glitch = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_drv", 32'(drv), 32'd0);
    check("rst_table", 32'(bus.table_obs), 32'd0);
    check("rst_match", 32'(bus.match), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Good block
    mode = 0;
    sweep(lat);
    check("good_latency", 32'(lat), 32'd177);
    check("good_table", 32'(bus.table_obs), 32'h1284);
    check("good_err", 32'(bus.err_mask), 32'h0000);
    check("good_unstable", 32'(bus.unstable_mask), 32'h0000);
    check("good_match", 32'(bus.match), 32'd1);
    check("good_busy_at_done", 32'(bus.busy), 32'd1);
    tick();
    check("good_done_pulse", 32'(bus.done), 32'd0);
    check("good_busy_after", 32'(bus.busy), 32'd0);
    check("good_hold_table", 32'(bus.table_obs), 32'h1284);

    // Output stuck at 0
    mode = 1;
    sweep(lat);
    check("zero_latency", 32'(lat), 32'd177);
    check("zero_table", 32'(bus.table_obs), 32'h0000);
    check("zero_err", 32'(bus.err_mask), 32'h1284);
    check("zero_match", 32'(bus.match), 32'd0);
    tick();

    // Row 6 inverted
    mode = 2;
    sweep(lat);
    check("row6_table", 32'(bus.table_obs), 32'h1084);
    check("row6_err", 32'(bus.err_mask), 32'h0200);
    check("row6_match", 32'(bus.match), 32'd0);
    tick();

    // Glitch between the two samples of row 0
    mode = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    glitch = 1'b1;
    tick();
    glitch = 1'b0;
    lat = 9;
    wait_done(lat);
    check("glitch_latency", 32'(lat), 32'd177);
    check("glitch_unstable", 32'(bus.unstable_mask), 32'h8000);
    check("glitch_table", 32'(bus.table_obs), 32'h9284);
    check("glitch_err", 32'(bus.err_mask), 32'h8000);
    check("glitch_match", 32'(bus.match), 32'd0);
    tick();

    // Abort during row 5 settle
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 57; i++) tick();
    check("abort_pre_drv", 32'(drv), 32'h5);
    check("abort_pre_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_drv", 32'(drv), 32'd0);
    check("abort_partial", 32'(bus.table_obs), 32'h1000);
    check("abort_match", 32'(bus.match), 32'd0);
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    sweep(lat);
    check("restart_latency", 32'(lat), 32'd177);
    check("restart_table", 32'(bus.table_obs), 32'h1284);
    check("restart_match", 32'(bus.match), 32'd1);
    tick();

    // start and abort together in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("collide_busy", 32'(bus.busy), 32'd0);
    tick();
    check("collide_idle", 32'(bus.busy), 32'd0);
    check("collide_match_kept", 32'(bus.match), 32'd1);

    // start held high across a sweep
    bus.start = 1'b1;
    tick();
    lat = 0;
    wait_done(lat);
    check("held_latency", 32'(lat), 32'd177);
    tick();
    check("held_single_pulse", 32'(bus.done), 32'd0);
    check("held_restart_busy", 32'(bus.busy), 32'd1);
    check("held_cleared_match", 32'(bus.match), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("held_row1_drv", 32'(drv), 32'h1);

    // Asynchronous reset mid-sweep, between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", 32'(bus.busy), 32'd0);
    check("areset_drv", 32'(drv), 32'd0);
    check("areset_done", 32'(bus.done), 32'd0);
    check("areset_table", 32'(bus.table_obs), 32'd0);
    bus.start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
